// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory op in flight, byte/half/word alignment,
// early error response for misaligned/illegal ops, and a BUSY watchdog.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] alu_addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  err_code,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

    state_t      state, state_nxt;
    logic [31:0] addr_q, data_q, rdata_q, cnt;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [4:0]  rd_q;
    logic [1:0]  err_q, err_nxt;
    logic        accept, illegal, misaligned, timeout, busy, resp, load_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept     = req_valid && req_ready;
    assign illegal    = is_store ? (funct3 >= 3'd3)
                                 : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
    assign misaligned = (funct3[1:0] == 2'b01 && alu_addr[0]) ||
                        (funct3[1:0] == 2'b10 && alu_addr[1:0] != 2'b00);
    // Fires on the TIMEOUT_CYCLES-th BUSY cycle; mem_ack in that cycle still wins.
    assign timeout    = (TMO != 32'd0) && (cnt + 32'd1 == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: if (accept) begin
                if (illegal)         begin state_nxt = RESP; err_nxt = 2'd2; end
                else if (misaligned) begin state_nxt = RESP; err_nxt = 2'd1; end
                else                 begin state_nxt = BUSY; err_nxt = 2'd0; end
            end
            BUSY: begin
                if (mem_ack)      begin state_nxt = RESP; err_nxt = 2'd0; end
                else if (timeout) begin state_nxt = RESP; err_nxt = 2'd3; end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            cnt      <= '0;
            funct3_q <= '0;
            store_q  <= 1'b0;
            rd_q     <= '0;
            err_q    <= '0;
        end else begin
            err_q <= err_nxt;
            if (accept) begin
                addr_q   <= alu_addr;
                data_q   <= store_data;
                funct3_q <= funct3;
                store_q  <= is_store;
                rd_q     <= rd_in;
                cnt      <= '0;
            end else if (busy) begin
                if (mem_ack) rdata_q <= mem_rdata;
                else         cnt     <= cnt + 32'd1;
            end
        end
    end

    assign busy = (state == BUSY);
    assign resp = (state == RESP);

    // Gated with rst_n so every output reads 0 while reset is held.
    assign req_ready = rst_n && (state == IDLE);
    assign stall     = (state != IDLE);
    assign mem_req   = busy;
    assign mem_we    = busy && store_q;
    assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        if (busy && store_q) begin
            case (funct3_q[1:0])
                2'b00:   begin mem_wstrb = 4'b0001 << addr_q[1:0]; mem_wdata = {4{data_q[7:0]}}; end
                2'b01:   begin mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{data_q[15:0]}}; end
                default: begin mem_wstrb = 4'b1111; mem_wdata = data_q; end
            endcase
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    assign load_ok    = resp && !store_q && (err_q == 2'd0);
    assign resp_valid = resp;
    assign err_code   = resp ? err_q : 2'd0;
    assign wb_we      = load_ok;
    assign wb_rd      = resp ? rd_q : 5'd0;
    assign wb_data    = load_ok ? ld_data : 32'd0;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum BUSY cycles without mem_ack before abort (0 = no timeout).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-004 req_valid  in  1  EX stage presents a memory op | req_ready  out  1  unit can accept.
REQ-005 alu_addr  in  32  effective address from ALU | store_data  in  32  rs2 value | funct3  in  3  RV32I width/sign code | is_store  in  1  1 = store, 0 = load | rd_in  in  5  load destination.
REQ-006 mem_req  out  1 | mem_we  out  1 | mem_addr  out  32 | mem_wstrb  out  4 | mem_wdata  out  32 | mem_ack  in  1 | mem_rdata  in  32: data-memory handshake.
REQ-007 resp_valid  out  1  one-cycle completion pulse | wb_we  out  1 | wb_rd  out  5 | wb_data  out  32 | err_code  out  2  (0 none, 1 misaligned, 2 illegal funct3, 3 timeout) | stall  out  1.

Function
REQ-008 SHALL implement states IDLE, BUSY, RESP; req_ready = (state==IDLE); stall = (state!=IDLE).
REQ-009 Accept when req_valid & req_ready at edge T; SHALL register addr, data, funct3, is_store, rd_in.
REQ-010 Legal accepted op: IDLE->BUSY; mem_req=1 from T+1 with mem_addr = {addr[31:2],2'b00}, mem_we = is_store.
REQ-011 mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata SHALL hold stable until the cycle mem_ack is sampled high; BUSY->RESP at that edge, mem_req=0 next cycle.
REQ-012 mem_ack outside BUSY SHALL be ignored.
REQ-013 RESP SHALL last exactly one cycle (resp_valid=1), then IDLE; minimum latency accept T -> resp_valid at T+2 (ack at T+1).
REQ-014 Store strobes: SB wstrb = 1<<addr[1:0], wdata = byte replicated x4; SH wstrb = 0011 (addr[1]=0) or 1100, wdata = half replicated x2; SW wstrb = 1111, wdata = store_data. Loads: wstrb = 0000.
REQ-015 Loads: mem_rdata captured on ack edge; LB/LBU select byte addr[1:0], LH/LHU select half addr[1], LW full word; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-016 In RESP: wb_we = 1 only for load with err_code 0; wb_rd = captured rd (rd=0 not suppressed); wb_data = aligned load data, else 0.
REQ-017 Illegal funct3 (load: 3,6,7; store: >=3) SHALL go IDLE->RESP directly, no mem_req, err_code=2.
REQ-018 Misaligned (H: addr[0]=1; W: addr[1:0]!=0) SHALL go IDLE->RESP directly, no mem_req, err_code=1; illegal funct3 takes priority.
REQ-019 BUSY cycle counter SHALL increment each BUSY cycle without ack; when count reaches TIMEOUT_CYCLES (nonzero) with no ack, BUSY->RESP, err_code=3, mem_req dropped; ack in that same cycle SHALL win (normal completion).
REQ-020 err_code, wb_we, wb_data, wb_rd SHALL be 0 whenever resp_valid=0.
REQ-021 A new request SHALL be accepted in the cycle after RESP (back-to-back, no bubble beyond RESP).

Reset
REQ-022 rst_n low SHALL immediately force IDLE, counter 0, all outputs 0 (incl. mem_req, req_ready), regardless of in-flight op.
REQ-023 In-flight op interrupted by reset SHALL be discarded: no resp_valid after release; req_ready=1 in the first cycle after release.

Verification
REQ-024 SW addr 0x100, data 0xDEADBEEF, ack T+1 -> mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, resp_valid at T+2, wb_we 0, err 0.
REQ-025 LB addr 0x203, mem_rdata 0x80112233, ack after 3 BUSY cycles -> mem_addr 0x200, wb_data 0xFFFFFF80, wb_we 1, mem_req held 3 cycles stable.
REQ-026 SH addr 0x102, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD; LHU 0x101 -> no mem_req, err_code 1 at T+1.
REQ-027 TIMEOUT_CYCLES=4, LW with no ack -> mem_req high 4 cycles, resp_valid with err_code 3, then req_ready 1.
REQ-028 rst_n low mid-BUSY -> mem_req 0 same cycle; after release no resp_valid, next LW accepted normally.
